// File: rtl/sc_decoder.sv
// Stochastic bitstream decoder: counts the ones in a window of 2^WIDTH valid
// samples and holds the count until the consumer accepts it.
module sc_decoder #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             busy,
  output logic [WIDTH:0]   out_value,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Sample count just before the final sample of a window is accepted.
  localparam logic [WIDTH:0] LAST_CNT = {1'b0, {WIDTH{1'b1}}};

  logic [1:0]     state_reg, state_next;
  logic [WIDTH:0] ones_reg, ones_next;
  logic [WIDTH:0] cnt_reg, cnt_next;

  always_comb begin
    state_next = state_reg;
    ones_next  = ones_reg;
    cnt_next   = cnt_reg;
    if (clear) begin
      state_next = IDLE;
      ones_next  = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = ACC;
            ones_next  = '0;
            cnt_next   = '0;
          end
        end
        ACC: begin
          if (in_valid) begin
            cnt_next  = cnt_reg + 1'b1;
            ones_next = ones_reg + {{WIDTH{1'b0}}, in_bit};
            if (cnt_reg == LAST_CNT) begin
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          // A start seen with the handshake chains straight into the next window.
          if (out_ready) begin
            state_next = start ? ACC : IDLE;
            ones_next  = '0;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          ones_next  = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ones_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ones_reg  <= ones_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign busy      = (state_reg == ACC);
  assign out_valid = (state_reg == HOLD);
  assign out_value = out_valid ? ones_reg : '0;

endmodule

// File: tb/tb_sc_decoder.sv
// Self-checking bench for sc_decoder: expected window counts are queued as
// stimulus is driven and compared when the result is handed off.
module tb_sc_decoder;
  localparam int WIDTH = 6;
  localparam int N = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst_n, start, clear, in_bit, in_valid, out_ready;
  logic busy, out_valid;
  logic [WIDTH:0] out_value;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sc_decoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .busy      (busy),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Scoreboard: every accepted result is matched against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_val("sb_unexpected_result", int'(out_value), -1);
      else check_val("sb_value", int'(out_value), exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_window(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val({tag, "_busy_after_start"}, int'(busy), 1);
  endtask

  // mode 0: zeros, 1: ones, 2: alternating 1/0. gap_every>0 inserts an idle
  // cycle every gap_every-th cycle. Pushes the model's count on the queue.
  task automatic run_window(input string tag, input int mode, input int gap_every);
    int sent = 0;
    int cyc = 0;
    int ones = 0;
    int gap_drop = 0;
    logic b;
    while (sent < N) begin
      if (gap_every > 0 && (cyc % gap_every) == gap_every - 1) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom_range(0, 1));
        tick();
        if (!busy) gap_drop++;
      end else begin
        b = (mode == 1) ? 1'b1 : (mode == 2) ? ((sent % 2) == 0) : 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        ones += int'(b);
        sent++;
        if (sent == N) exp_q.push_back(ones);
        tick();
        if (sent == N - 1) check_val({tag, "_not_done_early"}, int'(out_valid), 0);
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    if (gap_every > 0) check_val({tag, "_busy_drops_in_gaps"}, gap_drop, 0);
    check_val({tag, "_out_valid"}, int'(out_valid), 1);
    check_val({tag, "_busy_in_hold"}, int'(busy), 0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, "_idle_valid"}, int'(out_valid), 0);
    check_val({tag, "_idle_busy"}, int'(busy), 0);
    check_val({tag, "_idle_value"}, int'(out_value), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(out_valid), 0);
    check_val("rst_value", int'(out_value), 0);
    rst_n = 1'b1;

    // All ones, latency 2^WIDTH+1 from the start cycle.
    begin_window("ones");
    check_val("ones_valid_after_start", int'(out_valid), 0);
    check_val("ones_value_in_acc", int'(out_value), 0);
    run_window("ones", 1, 0);
    check_val("ones_value_direct", int'(out_value), N);
    handshake("ones");

    // Half density with an idle cycle every third cycle.
    begin_window("half");
    run_window("half", 2, 3);
    handshake("half");

    // Back-to-back windows: zeros then ones without a lost cycle.
    begin_window("b2b");
    run_window("b2b_zero", 0, 0);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check_val("b2b_busy_next", int'(busy), 1);
    check_val("b2b_valid_next", int'(out_valid), 0);
    run_window("b2b_one", 1, 0);
    handshake("b2b");

    // Backpressure: result held, inputs and start ignored.
    begin_window("bp");
    run_window("bp", 2, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_bit   = i[0];
      start    = ~i[0];
      tick();
      check_val("bp_value_stable", int'(out_value), N / 2);
      check_val("bp_valid_stable", int'(out_valid), 1);
    end
    start = 1'b0;
    in_valid = 1'b0;
    handshake("bp");
    tick();
    check_val("bp_start_not_queued", int'(busy), 0);

    // Abort after 20 samples, then a clean window.
    begin_window("abort");
    in_valid = 1'b1;
    in_bit = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_valid", int'(out_valid), 0);
    begin_window("abort_fresh");
    run_window("abort_fresh", 1, 0);
    handshake("abort_fresh");

    // Clear beats handshake and start in HOLD.
    begin_window("clrhold");
    run_window("clrhold", 0, 0);
    void'(exp_q.pop_back());
    clear = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0; start = 1'b0;
    check_val("clrhold_busy", int'(busy), 0);
    check_val("clrhold_valid", int'(out_valid), 0);

    // Reset mid-window at sample 40.
    begin_window("rstmid");
    in_valid = 1'b1;
    in_bit = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    rst_n = 1'b0;
    tick();
    check_val("rstmid_busy", int'(busy), 0);
    check_val("rstmid_valid", int'(out_valid), 0);
    check_val("rstmid_value", int'(out_value), 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    begin_window("rstmid_restart");
    run_window("rstmid_restart", 1, 0);
    handshake("rstmid_restart");

    check_val("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sc_decoder.md
SC_DECODER -- requirements
Module: sc_decoder

Interface
REQ-001 Parameter WIDTH, default 6, sets the bitstream window to 2^WIDTH sampled bits, matching the 6-bit random-number width of the stream encoders.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin a new conversion window.
REQ-005 clear  input  1  synchronous abort; discards the current window.
REQ-006 in_bit  input  1  stochastic bitstream sample.
REQ-007 in_valid  input  1  in_bit is valid this cycle.
REQ-008 busy  output  1  high while a window is being accumulated.
REQ-009 out_value  output  WIDTH+1  count of ones in the completed window, range 0..2^WIDTH.
REQ-010 out_valid  output  1  out_value holds a completed result.
REQ-011 out_ready  input  1  consumer accepts out_value.

Function
REQ-012 FSM states SHALL be IDLE, ACC and HOLD, with busy=1 only in ACC and out_valid=1 only in HOLD.
REQ-013 IDLE: start=1 SHALL move to ACC next cycle, clearing the ones counter and the sample counter to 0.
REQ-014 ACC: each cycle with in_valid=1 SHALL increment the sample counter by 1 and add in_bit to the ones counter; in_valid=0 SHALL leave both counters unchanged.
REQ-015 ACC: start SHALL be ignored.
REQ-016 ACC: the cycle that accepts the 2^WIDTH-th valid sample SHALL move the FSM to HOLD, with out_value including that sample, visible in the next cycle.
REQ-017 Latency from the start cycle to out_valid SHALL be exactly 2^WIDTH+1 cycles when in_valid is held at 1.
REQ-018 The sample counter SHALL be WIDTH+1 bits wide and SHALL never wrap; the ones counter SHALL be WIDTH+1 bits and SHALL never exceed 2^WIDTH.
REQ-019 HOLD: out_value and out_valid SHALL stay stable until out_valid and out_ready are both 1 in the same cycle; in_bit and in_valid SHALL be ignored.
REQ-020 HOLD handshake with start=0 SHALL go to IDLE.
REQ-021 HOLD handshake with start=1 SHALL go directly to ACC with the counters cleared, so back-to-back windows lose no cycle.
REQ-022 HOLD: start without the handshake SHALL be ignored and SHALL NOT be queued.
REQ-023 clear=1 in any state SHALL force IDLE next cycle, zero both counters and deassert out_valid; clear SHALL take priority over start and over the handshake.
REQ-024 out_value SHALL read 0 whenever the FSM is not in HOLD.

Reset
REQ-025 rst_n=0 sampled at a clock edge SHALL force IDLE, both counters to 0, busy=0, out_valid=0 and out_value=0; this SHALL hold whatever the state, including mid-window.
REQ-026 After rst_n returns to 1, the block SHALL accept start on the first following edge.

Verification
REQ-027 All-ones: start, then 64 cycles of in_valid=1 and in_bit=1 -> out_valid=1 with out_value=64 on cycle 65 after start; out_ready=1 -> IDLE.
REQ-028 Half density with gaps: 64 valid samples alternating 1/0, with in_valid=0 inserted every third cycle -> out_value=32; busy stays high through the gaps.
REQ-029 Back-to-back: a first window of all zeros, then out_ready=1 and start=1 in the same HOLD cycle -> out_value=0 is accepted, busy=1 next cycle, and a second all-ones window yields out_value=64.
REQ-030 Backpressure: out_ready=0 for 10 cycles in HOLD while in_bit toggles and start pulses -> out_value unchanged and no extra window started; then out_ready=1 -> IDLE.
REQ-031 Abort: clear=1 after 20 samples -> IDLE next cycle with busy=0; a fresh window of 64 ones -> out_value=64, with no carry-over from the aborted window.
REQ-032 Reset mid-window: rst_n=0 for one cycle at sample 40 -> all outputs 0 on the next cycle; start is accepted on the first edge after rst_n returns to 1.
